// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response mux with built-in default slave.
// Latches decoder selects on accepted address phases and routes the chosen slave's response.
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} dflt_state_t;

  localparam logic [4:0] PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

  logic [4:0]  sel_raw;
  logic [4:0]  sel_oh;
  logic [4:0]  sel_q;
  logic        dflt_d;
  logic        dflt_q;
  logic        unused_htrans0;
  dflt_state_t state;
  dflt_state_t state_nxt;

  assign sel_raw        = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  // Isolate the lowest set bit so the held select is always one-hot.
  assign sel_oh         = sel_raw & (~sel_raw + 5'd1);
  assign dflt_d         = (sel_raw == '0) & HTRANS[1];
  assign unused_htrans0 = HTRANS[0];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q  <= '0;
      dflt_q <= 1'b0;
      state  <= IDLE;
    end else begin
      if (HREADY) begin
        sel_q  <= sel_oh;
        dflt_q <= dflt_d;
      end
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (HREADY && dflt_d) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    if (HREADY) state_nxt = dflt_d ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (sel_q[0]) begin
      HREADY = P0_HREADYOUT;
      HRESP  = P0_HRESP;
      HRDATA = P0_HRDATA;
    end else if (sel_q[1]) begin
      HREADY = P1_HREADYOUT;
      HRESP  = P1_HRESP;
      HRDATA = P1_HRDATA;
    end else if (sel_q[2]) begin
      HREADY = P2_HREADYOUT;
      HRESP  = P2_HRESP;
      HRDATA = P2_HRDATA;
    end else if (sel_q[3]) begin
      HREADY = P3_HREADYOUT;
      HRESP  = P3_HRESP;
      HRDATA = P3_HRDATA;
    end else if (sel_q[4]) begin
      HREADY = P4_HREADYOUT;
      HRESP  = P4_HRESP;
      HRDATA = P4_HRDATA;
    end else if (dflt_q) begin
      HREADY = (state != ERR1);
      HRESP  = (state != IDLE);
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench for ahblite_slave_mux: directed scenarios plus random traffic,
// checked against a transfer-level model of the data phase.
module tb_ahblite_slave_mux;

  localparam logic [4:0] EN = 5'b01111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic        hsel[5];
  logic        s_ready[5];
  logic        s_resp[5];
  logic [31:0] s_rdata[5];
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_port = -1;   // port owning the current data phase, -1 if none
  int          m_err = 0;     // error cycles still to show: 2 = first, 1 = second
  logic [33:0] exp_out;       // {HREADY, HRESP, HRDATA}

  always #5 clk = ~clk;

  ahblite_slave_mux #(
    .Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1), .Port3_en(1'b1), .Port4_en(1'b0)
  ) dut (
    .HCLK(clk), .HRESET(rst), .HTRANS(htrans),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(s_ready[0]), .P1_HREADYOUT(s_ready[1]), .P2_HREADYOUT(s_ready[2]),
    .P3_HREADYOUT(s_ready[3]), .P4_HREADYOUT(s_ready[4]),
    .P0_HRDATA(s_rdata[0]), .P1_HRDATA(s_rdata[1]), .P2_HRDATA(s_rdata[2]),
    .P3_HRDATA(s_rdata[3]), .P4_HRDATA(s_rdata[4]),
    .P0_HRESP(s_resp[0]), .P1_HRESP(s_resp[1]), .P2_HRESP(s_resp[2]),
    .P3_HRESP(s_resp[3]), .P4_HRESP(s_resp[4]),
    .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp)
  );

  task automatic rand_slaves();
    for (int i = 0; i < 5; i++) begin
      s_ready[i] = ($urandom_range(0, 3) != 0);
      s_resp[i]  = 1'($urandom_range(0, 1));
      s_rdata[i] = $urandom;
    end
  endtask

  task automatic set_addr(input logic [1:0] tr, input logic [4:0] sel);
    htrans = tr;
    for (int i = 0; i < 5; i++) hsel[i] = sel[i];
  endtask

  // Wait for the sampling point and compute the expected bus response.
  task automatic sample();
    @(negedge clk);
    if (rst)              exp_out = {1'b1, 1'b0, 32'h0};
    else if (m_port >= 0) exp_out = {s_ready[m_port], s_resp[m_port], s_rdata[m_port]};
    else if (m_err == 2)  exp_out = {1'b0, 1'b1, 32'h0};
    else if (m_err == 1)  exp_out = {1'b1, 1'b1, 32'h0};
    else                  exp_out = {1'b1, 1'b0, 32'h0};
  endtask

  // Clock edge: a transfer is accepted whenever the bus was ready.
  task automatic advance();
    int hit;
    @(posedge clk);
    if (rst) begin
      m_port = -1;
      m_err  = 0;
    end else if (exp_out[33]) begin
      hit = -1;
      for (int i = 4; i >= 0; i--) if (hsel[i] && EN[i]) hit = i;
      m_port = hit;
      m_err  = (hit < 0 && htrans[1]) ? 2 : 0;
    end else if (m_err == 2) begin
      m_err = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_slaves();
      set_addr(2'($urandom_range(0, 3)), 5'($urandom));
      sample();
      n_checks++;
      if ({hready, hresp, hrdata} !== 34'h2_0000_0000) begin
        n_fail++;
        $display("FAIL reset c%0d: got %h required %h", c, {hready, hresp, hrdata}, 34'h2_0000_0000);
      end
      advance();
    end
    rst = 1'b0;
    set_addr(2'b00, 5'b0);
  endtask

  task automatic test_port_mux();
    rand_slaves();
    set_addr(2'b10, 5'b00010);
    sample();
    n_checks++;
    if ({hready, hresp, hrdata} !== exp_out) begin
      n_fail++;
      $display("FAIL port_mux addr: got %h required %h", {hready, hresp, hrdata}, exp_out);
    end
    advance();
    rand_slaves();
    s_rdata[1] = 32'hDEADBEEF;
    s_ready[1] = 1'b1;
    s_resp[1]  = 1'b0;
    set_addr(2'b00, 5'b0);
    sample();
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL port_mux data: got %h required %h", {hready, hresp, hrdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    end
    advance();
  endtask

  task automatic test_wait_states();
    rand_slaves();
    set_addr(2'b10, 5'b01000);
    sample();
    advance();
    for (int c = 0; c < 5; c++) begin
      rand_slaves();
      if (c < 3) s_ready[3] = 1'b0;
      if (c == 3) s_ready[3] = 1'b1;
      if (c == 4) s_ready[0] = 1'b1;
      if (c < 4) set_addr(2'b10, 5'b00001);
      else       set_addr(2'b00, 5'b0);
      sample();
      n_checks++;
      if ({hready, hresp, hrdata} !== exp_out) begin
        n_fail++;
        $display("FAIL wait_states c%0d: got %h required %h", c, {hready, hresp, hrdata}, exp_out);
      end
      if (c < 3) begin
        n_checks++;
        if (hready !== 1'b0 || hrdata !== s_rdata[3]) begin
          n_fail++;
          $display("FAIL wait_hold c%0d: got ready=%b data=%h required ready=0 data=%h", c, hready, hrdata, s_rdata[3]);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (hrdata !== s_rdata[0] || hready !== 1'b1) begin
          n_fail++;
          $display("FAIL wait_p0 : got ready=%b data=%h required ready=1 data=%h", hready, hrdata, s_rdata[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] req[4];
    req[0] = 2'b10; req[1] = 2'b01; req[2] = 2'b11; req[3] = 2'b10;  // {HREADY,HRESP}
    for (int c = 0; c < 4; c++) begin
      rand_slaves();
      set_addr((c == 0) ? 2'b10 : 2'b00, 5'b0);
      sample();
      n_checks++;
      if ({hready, hresp, hrdata} !== {req[c], 32'h0} || exp_out !== {req[c], 32'h0}) begin
        n_fail++;
        $display("FAIL unmapped c%0d: got %h required %h", c, {hready, hresp, hrdata}, {req[c], 32'h0});
      end
      advance();
    end
  endtask

  task automatic test_back_to_back_disabled();
    logic [1:0] req[6];
    req[0] = 2'b10; req[1] = 2'b01; req[2] = 2'b11;
    req[3] = 2'b01; req[4] = 2'b11; req[5] = 2'b10;
    for (int c = 0; c < 6; c++) begin
      rand_slaves();
      s_ready[4] = 1'b1;
      s_resp[4]  = 1'b0;
      set_addr((c < 3) ? 2'b10 : 2'b00, (c < 3) ? 5'b10000 : 5'b0);
      sample();
      n_checks++;
      if ({hready, hresp, hrdata} !== {req[c], 32'h0} || exp_out !== {req[c], 32'h0}) begin
        n_fail++;
        $display("FAIL disabled_p4 c%0d: got %h required %h", c, {hready, hresp, hrdata}, {req[c], 32'h0});
      end
      advance();
    end
  endtask

  task automatic test_reset_during_error();
    rand_slaves();
    set_addr(2'b10, 5'b0);
    sample();
    advance();
    set_addr(2'b00, 5'b0);
    sample();
    n_checks++;
    if ({hready, hresp} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_err pre: got %b required 01", {hready, hresp});
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== 34'h2_0000_0000) begin
      n_fail++;
      $display("FAIL rst_err async: got %h required %h", {hready, hresp, hrdata}, 34'h2_0000_0000);
    end
    exp_out = 34'h2_0000_0000;
    advance();
    rst = 1'b0;
    rand_slaves();
    set_addr(2'b10, 5'b00001);
    sample();
    advance();
    rand_slaves();
    s_ready[0] = 1'b1;
    s_resp[0]  = 1'b0;
    set_addr(2'b00, 5'b0);
    sample();
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, s_rdata[0]}) begin
      n_fail++;
      $display("FAIL rst_err after: got %h required %h", {hready, hresp, hrdata}, {1'b1, 1'b0, s_rdata[0]});
    end
    advance();
  endtask

  task automatic test_random();
    logic [4:0] sel;
    for (int c = 0; c < 400; c++) begin
      rand_slaves();
      sel = 5'($urandom) & 5'($urandom);
      set_addr(2'($urandom_range(0, 3)), sel);
      sample();
      n_checks++;
      if ({hready, hresp, hrdata} !== exp_out) begin
        n_fail++;
        $display("FAIL random c%0d: got %h required %h", c, {hready, hresp, hrdata}, exp_out);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) hsel[i] = 1'b0;
    rand_slaves();
    exp_out = 34'h2_0000_0000;
    test_reset();
    test_port_mux();
    test_wait_states();
    test_unmapped();
    test_back_to_back_disabled();
    test_reset_during_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
